// File: rtl/alu_result_serializer.sv
// Queues {carry, result} pairs from the ALU and streams each result out as
// LSB-first bytes with a valid/ready handshake. Back-to-back frames have no idle gap.
module alu_result_serializer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [2*WIDTH-1:0] Arith_OUT,
    input  logic               Carry_OUT,
    input  logic               Arith_Flag,
    input  logic               Byte_Ready,
    output logic [7:0]         Byte_Data,
    output logic               Byte_Valid,
    output logic               Byte_Last,
    output logic               Byte_Carry,
    output logic               Fifo_Full,
    output logic               Fifo_Empty,
    output logic               Overflow
);

    // state | meaning
    // IDLE  | no frame in flight; pops the FIFO head as soon as one is present
    // SEND  | shift register holds a result; one byte offered per transfer

    localparam int DW    = 2 * WIDTH;
    localparam int NB    = DW / 8;
    localparam int BC_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(NB - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     shift_q, shift_d;
    logic              carry_q, carry_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DW:0]       mem_q [DEPTH];
    logic [DW:0]       mem_d [DEPTH];

    logic              fifo_empty;
    logic              fifo_full;
    logic              last_byte;
    logic              xfer;
    logic              pop;
    logic              push;
    logic [DW:0]       head;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            carry_q  <= 1'b0;
            bcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            carry_q  <= carry_d;
            bcnt_q   <= bcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_FULL);
        last_byte  = (bcnt_q == LAST_IDX);
        xfer       = (state_q == ST_SEND) && Byte_Ready;
        // Emptiness is judged before this edge's write, so a fresh entry waits a cycle.
        pop        = !fifo_empty && ((state_q == ST_IDLE) || (xfer && last_byte));
        push       = Arith_Flag && (!fifo_full || pop);
        head       = mem_q[rd_ptr_q];

        state_d  = state_q;
        shift_d  = shift_q;
        carry_d  = carry_q;
        bcnt_d   = bcnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (Arith_Flag && !push);
        mem_d    = mem_q;

        if (pop) begin
            state_d  = ST_SEND;
            shift_d  = head[DW-1:0];
            carry_d  = head[DW];
            bcnt_d   = '0;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (xfer && last_byte) begin
            state_d = ST_IDLE;
            carry_d = 1'b0;
        end else if (xfer) begin
            shift_d = shift_q >> 8;
            bcnt_d  = bcnt_q + BC_W'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = {Carry_OUT, Arith_OUT};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        Byte_Valid = (state_q == ST_SEND);
        Byte_Data  = (state_q == ST_SEND) ? shift_q[7:0] : 8'h00;
        Byte_Last  = (state_q == ST_SEND) && last_byte;
        Byte_Carry = (state_q == ST_SEND) && carry_q;
        Fifo_Full  = fifo_full;
        Fifo_Empty = fifo_empty;
        Overflow   = ovf_q;
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed scenarios plus random traffic,
// every cycle compared against a queue-based model of results and pending bytes.
module tb_alu_result_serializer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Arith_OUT;
    logic        Carry_OUT;
    logic        Arith_Flag;
    logic        Byte_Ready;
    logic [7:0]  Byte_Data;
    logic        Byte_Valid;
    logic        Byte_Last;
    logic        Byte_Carry;
    logic        Fifo_Full;
    logic        Fifo_Empty;
    logic        Overflow;

    alu_result_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Arith_OUT  (Arith_OUT),
        .Carry_OUT  (Carry_OUT),
        .Arith_Flag (Arith_Flag),
        .Byte_Ready (Byte_Ready),
        .Byte_Data  (Byte_Data),
        .Byte_Valid (Byte_Valid),
        .Byte_Last  (Byte_Last),
        .Byte_Carry (Byte_Carry),
        .Fifo_Full  (Fifo_Full),
        .Fifo_Empty (Fifo_Empty),
        .Overflow   (Overflow)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: queued results, bytes still owed for the frame in flight, its carry.
    logic [32:0] m_fifo[$];
    logic [7:0]  m_frame[$];
    logic        m_carry = 1'b0;
    logic        m_ovf   = 1'b0;

    logic [8:0]  seen[$];
    int          seen_t[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic rst_b, input logic flag, input logic [31:0] a,
                              input logic c, input logic rdy);
        logic        valid;
        logic        last;
        logic        was_full;
        logic        pop_ok;
        logic [32:0] e;
        if (!rst_b) begin
            m_fifo.delete();
            m_frame.delete();
            m_carry = 1'b0;
            m_ovf   = 1'b0;
            return;
        end
        valid    = (m_frame.size() > 0);
        last     = (m_frame.size() == 1);
        was_full = (m_fifo.size() == DEPTH);
        pop_ok   = (m_fifo.size() > 0) && (!valid || (rdy && last));
        if (valid && rdy) void'(m_frame.pop_front());
        if (pop_ok) begin
            e       = m_fifo.pop_front();
            m_carry = e[32];
            for (int k = 0; k < 4; k++) m_frame.push_back(e[8*k +: 8]);
        end
        if (flag) begin
            if (!was_full || pop_ok) m_fifo.push_back({c, a});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic ev;
        ev = (m_frame.size() > 0);
        check_val("valid", 64'(Byte_Valid), 64'(ev));
        if (ev) begin
            check_val("data", 64'(Byte_Data), 64'(m_frame[0]));
            check_val("last", 64'(Byte_Last), 64'(m_frame.size() == 1));
        end else begin
            check_val("last_idle", 64'(Byte_Last), 64'(0));
        end
        check_val("carry", 64'(Byte_Carry), 64'(ev ? m_carry : 1'b0));
        check_val("full", 64'(Fifo_Full), 64'(m_fifo.size() == DEPTH));
        check_val("empty", 64'(Fifo_Empty), 64'(m_fifo.size() == 0));
        check_val("overflow", 64'(Overflow), 64'(m_ovf));
    endtask

    task automatic step(input logic rst_b, input logic flag, input logic [31:0] a,
                        input logic c, input logic rdy);
        RST        = rst_b;
        Arith_Flag = flag;
        Arith_OUT  = a;
        Carry_OUT  = c;
        Byte_Ready = rdy;
        if (rst_b && (Byte_Valid === 1'b1) && rdy) begin
            seen.push_back({Byte_Carry, Byte_Data});
            seen_t.push_back(cyc);
        end
        @(posedge CLK);
        model_edge(rst_b, flag, a, c, rdy);
        @(negedge CLK);
        cyc++;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp34 [8];
        int         thr;
        exp34 = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};

        // Reset, with a strobe during reset that must be ignored
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
        check_val("rst_data", 64'(Byte_Data), 64'(0));
        check_val("rst_empty", 64'(Fifo_Empty), 64'(1));
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check_val("rst_flag_ignored", 64'(Byte_Valid), 64'(0));

        // Single result, latency and byte order
        seen.delete(); seen_t.delete();
        step(1'b1, 1'b1, 32'd9, 1'b0, 1'b1);
        check_val("lat_edge_n", 64'(Byte_Valid), 64'(0));
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check_val("lat_edge_n1_valid", 64'(Byte_Valid), 64'(1));
        check_val("lat_edge_n1_data", 64'(Byte_Data), 64'(8'h09));
        repeat (6) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check_val("r9_count", 64'(seen.size()), 64'(4));
        for (int i = 0; i < seen.size() && i < 4; i++)
            check_val("r9_byte", 64'(seen[i]), 64'((i == 0) ? 9'h009 : 9'h000));
        check_val("r9_idle_empty", 64'(Fifo_Empty), 64'(1));

        // All-ones with carry, ready toggling
        seen.delete(); seen_t.delete();
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'd0, 1'b0, (i % 2) == 0);
        check_val("ff_count", 64'(seen.size()), 64'(4));
        for (int i = 0; i < seen.size() && i < 4; i++)
            check_val("ff_byte_carry", 64'(seen[i]), 64'(9'h1FF));

        // Back-to-back results without a bubble
        seen.delete(); seen_t.delete();
        step(1'b1, 1'b1, 32'd1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check_val("b2b_count", 64'(seen.size()), 64'(8));
        for (int i = 0; i < seen.size() && i < 8; i++)
            check_val("b2b_byte", 64'(seen[i]), 64'({1'b0, exp34[i]}));
        if (seen_t.size() == 8)
            check_val("b2b_no_gap", 64'(seen_t[7] - seen_t[0]), 64'(7));

        // Fill while stalled, overflow on the sixth strobe
        seen.delete(); seen_t.delete();
        for (int k = 0; k < 6; k++)
            step(1'b1, 1'b1, 32'h1111_1111 * (k + 1), 1'b0, 1'b0);
        check_val("ovf_full", 64'(Fifo_Full), 64'(1));
        check_val("ovf_flag", 64'(Overflow), 64'(1));
        repeat (30) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check_val("ovf_bytes", 64'(seen.size()), 64'(20));
        for (int r = 0; r < 5 && 4 * r < seen.size(); r++)
            check_val("ovf_frame_byte0", 64'(seen[4*r]), 64'(9'((r + 1) * 8'h11)));
        check_val("ovf_sticky", 64'(Overflow), 64'(1));

        // Reset mid-frame with two results queued
        step(1'b1, 1'b1, 32'hA0A1_A2A3, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'hB0B1_B2B3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'hC0C1_C2C3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        check_val("mid_rst_valid", 64'(Byte_Valid), 64'(0));
        check_val("mid_rst_empty", 64'(Fifo_Empty), 64'(1));
        check_val("mid_rst_ovf", 64'(Overflow), 64'(0));
        seen.delete(); seen_t.delete();
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        check_val("mid_rst_silent", 64'(seen.size()), 64'(0));

        // Random traffic with varying backpressure and occasional reset
        for (int blk = 0; blk < 6; blk++) begin
            thr = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 6 : 10);
            for (int i = 0; i < 100; i++)
                step($urandom_range(0, 99) != 0,
                     $urandom_range(0, 9) < 4,
                     $urandom,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 9) < thr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
